// File: rtl/seg7_to_bcd_encoder.sv
// seg7_to_bcd_encoder
// Reads an active-low 7-segment bus, waits for a stable pattern and emits the
// BCD digit it displays on a valid/ready output. Each distinct pattern is
// reported once. The error glyph and unknown patterns get their own flags.
// Unknown patterns that the consumer accepts are counted, and the count saturates.
module seg7_to_bcd_encoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [0:6]       SEG_IN,
  input  logic             OUT_READY,
  output logic             OUT_VALID,
  output logic [3:0]       BCD,
  output logic             ERR_GLYPH,
  output logic             INVALID,
  output logic [CNT_W-1:0] INVALID_CNT,
  output logic             BUSY
);

  // The stability counter only has to reach STABLE_CYCLES-1.
  localparam int STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [0:6]        BLANK     = 7'b1111111;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_EMIT   = 2'd2
  } state_t;

  // Table lookup: returns {bcd[3:0], err_glyph, invalid}.
  // The blank pattern falls into the default branch, but it never reaches an
  // emit because the FSM filters it out first.
  function automatic logic [5:0] encode(input logic [0:6] pat);
    logic [5:0] r;
    case (pat)
      7'b0000001: r = {4'h0, 1'b0, 1'b0};
      7'b1001111: r = {4'h1, 1'b0, 1'b0};
      7'b0010010: r = {4'h2, 1'b0, 1'b0};
      7'b0000110: r = {4'h3, 1'b0, 1'b0};
      7'b1001100: r = {4'h4, 1'b0, 1'b0};
      7'b0100100: r = {4'h5, 1'b0, 1'b0};
      7'b0100000: r = {4'h6, 1'b0, 1'b0};
      7'b0001111: r = {4'h7, 1'b0, 1'b0};
      7'b0000000: r = {4'h8, 1'b0, 1'b0};
      7'b0000100: r = {4'h9, 1'b0, 1'b0};
      7'b0101010: r = {4'hE, 1'b1, 1'b0};
      default:    r = {4'hF, 1'b0, 1'b1};
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [0:6]        sync1_q, sync1_d;
  logic [0:6]        sync2_q, sync2_d;
  logic [0:6]        cand_q, cand_d;
  logic [0:6]        last_q, last_d;
  logic [STAB_W-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [3:0]        bcd_q, bcd_d;
  logic              err_q, err_d;
  logic              inv_q, inv_d;
  logic [CNT_W-1:0]  inv_cnt_q, inv_cnt_d;
  logic [5:0]        enc;
  logic [0:6]        s;

  // The FSM only ever looks at the second synchronizer stage.
  assign s   = sync2_q;
  assign enc = encode(cand_q);

  // Next-state logic: synchronizer shift, stability tracking and the output handshake.
  always_comb begin
    state_d   = state_q;
    sync1_d   = SEG_IN;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    inv_d     = inv_q;
    inv_cnt_d = inv_cnt_q;

    case (state_q)
      S_IDLE: begin
        // Only a change relative to the last reported pattern wakes the FSM.
        if (s != last_q) begin
          state_d = S_SETTLE;
          cand_d  = s;
          cnt_d   = STAB_ONE;
        end
      end

      S_SETTLE: begin
        if (s != cand_q) begin
          // The pattern moved before it settled, so start counting again.
          cand_d = s;
          cnt_d  = STAB_ONE;
        end else if (cnt_q == STAB_LAST) begin
          if (cand_q == BLANK) begin
            // A blank is remembered so that the same digit can be reported again, but blank itself is never reported.
            last_d  = BLANK;
            state_d = S_IDLE;
          end else begin
            {bcd_d, err_d, inv_d} = enc;
            valid_d = 1'b1;
            state_d = S_EMIT;
          end
        end else begin
          cnt_d = cnt_q + STAB_ONE;
        end
      end

      S_EMIT: begin
        // The result fields stay frozen here. SEG_IN movement is picked up later by the IDLE compare.
        if (OUT_READY) begin
          valid_d = 1'b0;
          last_d  = cand_q;
          if (inv_q && (inv_cnt_q != CNT_MAX)) begin
            inv_cnt_d = inv_cnt_q + 1'b1;
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register. The asynchronous reset clears any pending result.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      sync1_q   <= BLANK;
      sync2_q   <= BLANK;
      cand_q    <= BLANK;
      last_q    <= BLANK;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      bcd_q     <= 4'h0;
      err_q     <= 1'b0;
      inv_q     <= 1'b0;
      inv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      inv_q     <= inv_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

  assign OUT_VALID   = valid_q;
  assign BCD         = bcd_q;
  assign ERR_GLYPH   = err_q;
  assign INVALID     = inv_q;
  assign INVALID_CNT = inv_cnt_q;
  assign BUSY        = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg7_to_bcd_encoder.sv
// tb_seg7_to_bcd_encoder
// Directed stimulus drives the segment bus. Each pattern that should be reported
// pushes its expected {bcd, err, inv} onto a scoreboard. The monitor pops an
// entry on every accepted result and compares it with the outputs.
module tb_seg7_to_bcd_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:6] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] bcd;
  logic       err_glyph;
  logic       invalid;
  logic [7:0] invalid_cnt;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  logic [5:0] sb[$];
  logic [5:0] mon_exp;

  logic [0:6] digit_pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

  always #10 clk = ~clk;

  seg7_to_bcd_encoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .SEG_IN     (seg_in),
    .OUT_READY  (out_ready),
    .OUT_VALID  (out_valid),
    .BCD        (bcd),
    .ERR_GLYPH  (err_glyph),
    .INVALID    (invalid),
    .INVALID_CNT(invalid_cnt),
    .BUSY       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_bcd"},   32'(bcd),       32'(0));
    check({tag, "_err"},   32'(err_glyph), 32'(0));
    check({tag, "_inv"},   32'(invalid),   32'(0));
    check({tag, "_cnt"},   32'(invalid_cnt), 32'(0));
    check({tag, "_busy"},  32'(busy),      32'(0));
  endtask

  // Scoreboard monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("sb_bcd", 32'(bcd),       32'(mon_exp[5:2]));
        check("sb_err", 32'(err_glyph), 32'(mon_exp[1]));
        check("sb_inv", 32'(invalid),   32'(mon_exp[0]));
      end
      accepted++;
    end
  end

  initial begin
    rst_n     = 1'b0;
    seg_in    = 7'b1111111;
    out_ready = 1'b1;
    ticks(3);
    check_reset_values("reset");
    rst_n = 1'b1;

    // 1: blank bus held, so nothing is reported.
    ticks(20);
    check("blank_valid", 32'(out_valid), 32'(0));
    check("blank_busy",  32'(busy),      32'(0));
    check("blank_count", 32'(accepted),  32'(0));

    // 2: digit 2, latency E+5 and a single-cycle pulse.
    seg_in = 7'b0010010;
    sb.push_back({4'h2, 1'b0, 1'b0});
    ticks(5);
    check("lat_early_valid", 32'(out_valid), 32'(0));
    check("lat_busy",        32'(busy),      32'(1));
    tick();
    check("lat_valid", 32'(out_valid), 32'(1));
    check("lat_bcd",   32'(bcd),       32'(2));
    tick();
    check("pulse_end", 32'(out_valid), 32'(0));
    ticks(20);
    check("no_reemit", 32'(accepted), 32'(1));

    // 3: digits 0..9 in order, then the error glyph.
    for (int i = 0; i < 10; i++) begin
      seg_in = digit_pat[i];
      sb.push_back({4'(i), 1'b0, 1'b0});
      ticks(10);
    end
    seg_in = 7'b0101010;
    sb.push_back({4'hE, 1'b1, 1'b0});
    ticks(10);
    check("seq_count", 32'(accepted),  32'(12));
    check("err_hold",  32'(err_glyph), 32'(1));
    check("err_bcd",   32'(bcd),       32'(4'hE));

    // 4: a short glitch on 3, then 4 held, gives exactly one result.
    seg_in = 7'b0000110;
    ticks(2);
    seg_in = 7'b1001100;
    sb.push_back({4'h4, 1'b0, 1'b0});
    ticks(12);
    check("glitch_count", 32'(accepted), 32'(13));
    check("glitch_bcd",   32'(bcd),      32'(4));

    // 5: backpressure holds 1 stable while the bus already shows 7.
    out_ready = 1'b0;
    seg_in    = 7'b1001111;
    sb.push_back({4'h1, 1'b0, 1'b0});
    ticks(8);
    seg_in = 7'b0001111;
    sb.push_back({4'h7, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_bcd",   32'(bcd),       32'(1));
    end
    out_ready = 1'b1;
    ticks(12);
    check("bp_count", 32'(accepted), 32'(15));
    check("bp_bcd",   32'(bcd),      32'(7));

    // 6: 300 alternating invalid patterns, and the counter saturates.
    for (int i = 0; i < 300; i++) begin
      seg_in = (i % 2 == 1) ? 7'b1111101 : 7'b1111110;
      sb.push_back({4'hF, 1'b0, 1'b1});
      ticks(8);
      if (i == 9) check("inv_cnt_10", 32'(invalid_cnt), 32'(10));
    end
    check("inv_cnt_sat", 32'(invalid_cnt), 32'(255));
    check("inv_flag",    32'(invalid),     32'(1));
    check("inv_bcd",     32'(bcd),         32'(4'hF));
    check("inv_count",   32'(accepted),    32'(315));

    // Reset asserted during EMIT drops the pending result at once.
    out_ready = 1'b0;
    seg_in    = 7'b0000000;
    ticks(8);
    check("pre_rst_valid", 32'(out_valid), 32'(1));
    check("pre_rst_bcd",   32'(bcd),       32'(8));
    seg_in = 7'b1111111;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    ticks(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    ticks(20);
    check("post_rst_valid", 32'(out_valid), 32'(0));
    check("post_rst_busy",  32'(busy),      32'(0));
    check("final_count",    32'(accepted),  32'(315));
    check("sb_drained",     32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
